mem_1_master: RTL and testbench
===============================

# mem_1_master

Avalon-MM initiator that drives the 1024×32 on-chip RAM slave port (10-bit word address, clken/chipselect/write, 4-bit byteenable, fixed one-cycle read latency). Accepts a single command at a time and either fills a contiguous, wrapping address range with an incrementing pattern or reads a range back and returns a 32-bit modular sum. Sits between test/control logic and the RAM and runs memory bring-up and self-check sequences.

## Interface

- ADDR_W, 10, RAM word-address width; also sets the range length width to ADDR_W+1.
- DATA_W, 32, RAM data width; byteenable is DATA_W/8 bits.

- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid & cmd_ready.
- cmd_op  in  1  0 = FILL, 1 = READSUM.
- cmd_addr  in  ADDR_W  start word address.
- cmd_len  in  ADDR_W+1  word count, 0..2^ADDR_W.
- cmd_pattern  in  DATA_W  FILL base value; ignored for READSUM.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse at command completion.
- result  out  DATA_W  READSUM sum; 0 after FILL or a zero-length command; held until the next accept.
- mem_address  out  ADDR_W  RAM address.
- mem_clken  out  1  RAM clock enable.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  1 = write, 0 = read.
- mem_writedata  out  DATA_W  write data.
- mem_byteenable  out  DATA_W/8  all ones during accesses, 0 otherwise.
- mem_readdata  in  DATA_W  valid one cycle after a read access.

## Operation

- States: IDLE, FILL, READ, DRAIN, DONE.
- IDLE: cmd_ready = 1. On accept, latch addr, len, op, and pattern. Clear index i and result.
  - len = 0: go to DONE.
  - op = 0: go to FILL.
  - op = 1: go to READ.
- FILL: one access per cycle with mem_clken = mem_chipselect = mem_write = 1.
  - mem_address = (addr + i) mod 2^ADDR_W.
  - mem_writedata = (pattern + i) mod 2^DATA_W.
  - After i = len−1, go to DONE.
- READ: one read per cycle with mem_clken = mem_chipselect = 1 and mem_write = 0, using the same address rule as FILL.
  - Registered read-valid flag tracks the one-cycle latency.
  - When the flag is set, result += mem_readdata (mod 2^DATA_W).
  - After the read at i = len−1, go to DRAIN.
- DRAIN: no access; capture the final read word; go to DONE.
- DONE: done = 1 for one cycle, then return to IDLE.
- Outside FILL/READ, all mem_* outputs are 0.
- cmd_valid while busy is ignored. It is not queued and has no effect.
- Address wrap: 0x3FF + 1 → 0x000. Pattern wrap: 0xFFFFFFFF + 1 → 0x00000000.
- len = 2^ADDR_W covers every word exactly once.

## Timing

- Reset (reset_n low, asynchronous): state = IDLE.
  - cmd_ready = 1; commands are ignored until reset_n is high at a clock edge.
  - busy, done, result, and all mem_* outputs = 0.
- Accept at edge T, len = N > 0:
  - FILL: accesses in cycles T+1..T+N; done in cycle T+N+1.
  - READSUM: reads in cycles T+1..T+N; last data sampled in T+N+1 (DRAIN); done and final result in T+N+2.
- len = 0: done in cycle T+1, result = 0.
- Earliest next accept is the cycle after done. Back-to-back commands leave one idle cycle.
- Throughput: one RAM access per cycle, with no bubbles inside a command.
- Reset asserted mid-command: immediate abort to IDLE with no done pulse. RAM contents are partially written and undefined; the bench must not check them.

## Test plan

- FILL, addr 0x3FE, len 4, pattern 0x10 -> writes (0x3FE,0x10), (0x3FF,0x11), (0x000,0x12), (0x001,0x13) in T+1..T+4; done at T+5; result = 0.
- READSUM of the same range against a RAM model with one-cycle read latency -> done at T+6; result = 0x46; no write strobes seen.
- FILL addr 0, len 2, pattern 0x80000000, then READSUM of the range -> data 0x80000000 and 0x80000001; result = 0x00000001 (sum wraps).
- len = 0 with either op -> no mem access; done at T+1; result = 0.
- FILL, len 1024, addr 0x200 -> every address written exactly once (0x200..0x3FF then 0x000..0x1FF); done at T+1025. A cmd_valid pulse mid-run is ignored and cmd_ready stays 0.
- Reset during READSUM (len 8, reset_n low at i = 3) -> all outputs 0 at once; no done pulse; cmd_ready = 1. A new len-1 READSUM after release completes normally with done at T+3.

Source files
------------

// File: rtl/mem_1_master.sv
// Avalon-MM initiator for a 1024x32 single-port RAM: fills a wrapping address
// range with an incrementing pattern, or reads a range back and sums it.
module mem_1_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [ADDR_W:0]       cmd_len,
  input  logic [DATA_W-1:0]     cmd_pattern,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     result,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_clken,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W:0]     len_reg, len_next;
  logic [DATA_W-1:0]   pattern_reg, pattern_next;
  logic [ADDR_W:0]     idx_reg, idx_next;
  logic [DATA_W-1:0]   result_reg, result_next;
  logic                rd_valid_reg, rd_valid_next;

  logic                access;
  logic                last_idx;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_data;

  // idx never exceeds len-1 <= 2^ADDR_W-1, so its low bits alone give the offset
  assign cur_addr = addr_reg + idx_reg[ADDR_W-1:0];
  assign cur_data = pattern_reg + DATA_W'(idx_reg);
  assign last_idx = (idx_reg == (len_reg - (ADDR_W+1)'(1)));
  assign access   = (state_reg == ST_FILL) || (state_reg == ST_READ);

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    len_next      = len_reg;
    pattern_next  = pattern_reg;
    idx_next      = idx_reg;
    result_next   = result_reg;
    rd_valid_next = (state_reg == ST_READ);

    // Read data lands one cycle after each READ cycle, including into DRAIN
    if (rd_valid_reg) begin
      result_next = result_reg + mem_readdata;
    end

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_next    = cmd_addr;
          len_next     = cmd_len;
          pattern_next = cmd_pattern;
          idx_next     = '0;
          result_next  = '0;
          if (cmd_len == '0) begin
            state_next = ST_DONE;
          end else if (cmd_op) begin
            state_next = ST_READ;
          end else begin
            state_next = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        idx_next = idx_reg + (ADDR_W+1)'(1);
        if (last_idx) begin
          state_next = ST_DONE;
        end
      end
      ST_READ: begin
        idx_next = idx_reg + (ADDR_W+1)'(1);
        if (last_idx) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      len_reg      <= '0;
      pattern_reg  <= '0;
      idx_reg      <= '0;
      result_reg   <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      len_reg      <= len_next;
      pattern_reg  <= pattern_next;
      idx_reg      <= idx_next;
      result_reg   <= result_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  // Bus outputs are decoded from state so a reset silences them immediately
  assign cmd_ready      = (state_reg == ST_IDLE);
  assign busy           = (state_reg != ST_IDLE);
  assign done           = (state_reg == ST_DONE);
  assign result         = result_reg;
  assign mem_address    = access ? cur_addr : '0;
  assign mem_clken      = access;
  assign mem_chipselect = access;
  assign mem_write      = (state_reg == ST_FILL);
  assign mem_writedata  = (state_reg == ST_FILL) ? cur_data : '0;

  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_be
      assign mem_byteenable[gi] = access;
    end
  endgenerate

endmodule

// File: tb/tb_mem_1_master.sv
// Randomized self-checking bench for mem_1_master with a one-cycle-latency RAM
// model and a shadow-memory reference that predicts every access and sum.
module tb_mem_1_master;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                clk;
  logic                reset_n;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_op;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [ADDR_W:0]     cmd_len;
  logic [DATA_W-1:0]   cmd_pattern;
  logic                busy;
  logic                done;
  logic [DATA_W-1:0]   result;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_clken;
  logic                mem_chipselect;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic [DATA_W-1:0]   mem_readdata;

  mem_1_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .cmd_pattern    (cmd_pattern),
    .busy           (busy),
    .done           (done),
    .result         (result),
    .mem_address    (mem_address),
    .mem_clken      (mem_clken),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_readdata   (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM slave: byte-enabled write, registered read
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
        end
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  logic [DATA_W-1:0] ref_mem [DEPTH];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bus_vec();
    return 64'({mem_clken, mem_chipselect, mem_write, mem_byteenable, mem_address, mem_writedata});
  endfunction

  // Issue one command and check it cycle by cycle; poke_at >= 0 raises a
  // stray cmd_valid during that access cycle.
  task automatic run_cmd(input logic op, input logic [ADDR_W-1:0] addr,
                         input logic [ADDR_W:0] len, input logic [DATA_W-1:0] pat,
                         input int poke_at, output logic [DATA_W-1:0] got);
    logic [DATA_W-1:0] exp_res;
    logic [DATA_W-1:0] ew;
    logic [ADDR_W-1:0] ea;
    int n;
    n = int'(len);
    exp_res = '0;
    @(negedge clk);
    check("ready_before", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_pattern = pat;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      ea = addr + ADDR_W'(k);
      ew = pat + DATA_W'(k);
      check("run_flags", {busy, cmd_ready, done}, 3'b100);
      check("acc_addr", mem_address, ea);
      check("acc_ctl", {mem_clken, mem_chipselect, mem_write, mem_byteenable},
            {1'b1, 1'b1, ~op, 4'hF});
      if (!op) begin
        check("acc_wdata", mem_writedata, ew);
        ref_mem[ea] = ew;
      end else begin
        exp_res = exp_res + ref_mem[ea];
      end
      if (k == poke_at) begin
        cmd_valid = 1'b1; cmd_op = ~op; cmd_len = 1; cmd_addr = ~addr;
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (op && n != 0) begin
      check("drain_flags", {busy, cmd_ready, done}, 3'b100);
      check("drain_bus", bus_vec(), 0);
      @(negedge clk);
    end
    check("done_flags", {done, busy, cmd_ready}, 3'b110);
    check("done_bus", bus_vec(), 0);
    check("done_result", result, exp_res);
    got = result;
    @(negedge clk);
    check("idle_flags", {done, busy, cmd_ready}, 3'b001);
    check("result_hold", result, exp_res);
    $display("cmd op=%0d addr=0x%03h len=%0d pattern=0x%08h result=0x%08h",
             op, addr, len, pat, got);
  endtask

  initial begin
    logic [DATA_W-1:0] got;
    logic              op;
    logic [ADDR_W:0]   len;
    int                r;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0;
    cmd_addr = '0; cmd_len = '0; cmd_pattern = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    #2;
    check("rst_flags", {cmd_ready, busy, done}, 3'b100);
    check("rst_result", result, 0);
    check("rst_bus", bus_vec(), 0);
    // A command offered while reset is held must be ignored
    cmd_valid = 1'b1; cmd_len = 3;
    repeat (2) @(negedge clk);
    check("rst_ignore", {cmd_ready, busy}, 2'b10);
    cmd_valid = 1'b0;
    reset_n = 1'b1;

    // Full-range wrapping fill defines all of memory; stray cmd_valid mid-run
    run_cmd(1'b0, 10'h200, 11'd1024, $urandom, 500, got);

    run_cmd(1'b0, 10'h3FE, 11'd4, 32'h10, -1, got);
    check("plan_fill_res", got, 0);
    run_cmd(1'b1, 10'h3FE, 11'd4, 32'h0, -1, got);
    check("plan_sum_46", got, 32'h46);
    run_cmd(1'b0, 10'h000, 11'd2, 32'h8000_0000, -1, got);
    run_cmd(1'b1, 10'h000, 11'd2, 32'h0, -1, got);
    check("plan_sum_wrap", got, 32'h1);
    run_cmd(1'b0, 10'h123, 11'd0, 32'hABCD, -1, got);
    run_cmd(1'b1, 10'h3FF, 11'd0, 32'h0, -1, got);

    // Reset asserted during the 4th read of an 8-word READSUM
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 10'h3FE; cmd_len = 8;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_pre_addr", mem_address, 10'h001);
    reset_n = 1'b0;
    #1;
    check("abort_flags", {cmd_ready, busy, done}, 3'b100);
    check("abort_result", result, 0);
    check("abort_bus", bus_vec(), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_quiet", {done, busy, mem_clken}, 3'b000);
    end
    reset_n = 1'b1;
    run_cmd(1'b1, 10'h005, 11'd1, 32'h0, -1, got);

    for (int t = 0; t < 30; t++) begin
      op = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 9));
      if (r == 0)      len = 0;
      else if (r == 9) len = 11'($urandom_range(0, DEPTH));
      else             len = 11'($urandom_range(1, 40));
      run_cmd(op, 10'($urandom), len, $urandom, -1, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
